// File: rtl/pdpu_exp_max_seq.sv
`default_nettype none
// ============================================================================
// Module   : pdpu_exp_max_seq (+ pdpu_comp_tree)
// Brief    : Streams an exponent vector N lanes per beat through one shared
//            comparator tree and reports the vector-wide signed maximum.
// Revision : 1.0 - initial release
// ============================================================================

module pdpu_comp_tree #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic [N*(WIDTH+1)-1:0] exp_i,
  output logic signed [WIDTH:0]  max_o
);

  always_comb begin
    max_o = exp_i[WIDTH:0];
    for (int i = 1; i < N; i++) begin
      if ($signed(exp_i[i*(WIDTH+1) +: WIDTH+1]) > max_o) begin
        max_o = exp_i[i*(WIDTH+1) +: WIDTH+1];
      end
    end
  end

endmodule

module pdpu_exp_max_seq #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N*(WIDTH+1)-1:0] exp_i,
  input  logic [N-1:0]           mask_i,
  input  logic                   last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic signed [WIDTH:0]  max_exp_o,
  output logic                   empty_o,
  output logic [CW-1:0]          beat_cnt_o,
  output logic                   ovf_o
);

  localparam logic signed [WIDTH:0] MIN_EXP = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CW-1:0]         CNT_MAX = CW'(MAX_BEATS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                  state;
  logic [N*(WIDTH+1)-1:0]  masked_exp;
  logic signed [WIDTH:0]   tree_max;
  logic                    any_en;

  // Disabled lanes become MIN so they can never win the comparison.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign masked_exp[i*(WIDTH+1) +: WIDTH+1] =
      mask_i[i] ? exp_i[i*(WIDTH+1) +: WIDTH+1] : MIN_EXP;
  end

  pdpu_comp_tree #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_tree (
    .exp_i (masked_exp),
    .max_o (tree_max)
  );

  assign any_en = |mask_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      max_exp_o   <= MIN_EXP;
      empty_o     <= 1'b1;
      beat_cnt_o  <= '0;
      ovf_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            max_exp_o  <= tree_max;
            beat_cnt_o <= CW'(1);
            empty_o    <= ~any_en;
            ovf_o      <= 1'b0;
            if (last_i) begin
              state       <= S_OUT;
              in_ready_o  <= 1'b0;
              out_valid_o <= 1'b1;
            end else begin
              state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (in_valid_i) begin
            if (tree_max > max_exp_o) begin
              max_exp_o <= tree_max;
            end
            // Count saturates; a further non-final beat marks overflow.
            if (beat_cnt_o == CNT_MAX) begin
              if (!last_i) begin
                ovf_o <= 1'b1;
              end
            end else begin
              beat_cnt_o <= beat_cnt_o + CW'(1);
            end
            empty_o <= empty_o & ~any_en;
            if (last_i) begin
              state       <= S_OUT;
              in_ready_o  <= 1'b0;
              out_valid_o <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            state       <= S_IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            ovf_o       <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pdpu_exp_max_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdpu_exp_max_seq
// Brief    : Scoreboard bench for the streaming max-exponent sequencer.
// Revision : 1.0 - initial release
// ============================================================================

module tb_pdpu_exp_max_seq;

  localparam int N = 4;
  localparam int WIDTH = 8;
  localparam int MAX_BEATS = 16;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int MIN_V = -256;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [N*(WIDTH+1)-1:0] exp_v = '0;
  logic [N-1:0]           mask = '0;
  logic                   last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic signed [WIDTH:0]  max_exp;
  logic                   empty;
  logic [CW-1:0]          beat_cnt;
  logic                   ovf;

  int tests = 0;
  int fails = 0;
  bit stall = 1'b0;
  bit after_hs = 1'b0;

  typedef struct {
    int mx;
    bit emp;
    int cnt;
    bit ovf;
  } exp_t;
  exp_t sbq[$];

  // Reference model state for the vector under construction
  int v_n = 0;
  int v_max = 0;
  bit v_any = 1'b0;

  pdpu_exp_max_seq #(.N(N), .WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .exp_i       (exp_v),
    .mask_i      (mask),
    .last_i      (last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .max_exp_o   (max_exp),
    .empty_o     (empty),
    .beat_cnt_o  (beat_cnt),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] pack(int a, int b, int c, int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  task automatic model_clear();
    v_n = 0;
    v_max = MIN_V;
    v_any = 1'b0;
  endtask

  task automatic send_beat(input logic [35:0] e, input logic [3:0] m, input bit lst);
    int guard;
    logic signed [8:0] lane;
    exp_t x;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      fails++;
      tests++;
      $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
      return;
    end
    exp_v = e;
    mask = m;
    last = lst;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    v_n++;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        lane = e[i*9 +: 9];
        if (!v_any || int'(lane) > v_max) v_max = int'(lane);
        v_any = 1'b1;
      end
    end
    if (lst) begin
      x.mx  = v_any ? v_max : MIN_V;
      x.emp = !v_any;
      x.cnt = (v_n > MAX_BEATS) ? MAX_BEATS : v_n;
      x.ovf = (v_n > MAX_BEATS + 1);
      sbq.push_back(x);
      model_clear();
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sbq.size() != 0 || out_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: pending=%0d required 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Result consumer: random backpressure unless a stall is requested
  initial begin
    forever begin
      @(posedge clk);
      #1 out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: checks every valid cycle against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) begin
      after_hs = 1'b0;
    end else begin
      if (after_hs) begin
        tests++;
        if (!in_ready || out_valid) begin
          fails++;
          $display("FAIL post_handshake: in_ready=%0b out_valid=%0b required 1 0",
                   in_ready, out_valid);
        end
        after_hs = 1'b0;
      end
      if (out_valid) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result: max=%0d cnt=%0d with no result expected",
                   max_exp, beat_cnt);
        end else begin
          if (int'(max_exp) != sbq[0].mx || empty != sbq[0].emp ||
              int'(beat_cnt) != sbq[0].cnt || ovf != sbq[0].ovf || in_ready) begin
            fails++;
            $display("FAIL result: max=%0d empty=%0b cnt=%0d ovf=%0b rdy=%0b required max=%0d empty=%0b cnt=%0d ovf=%0b rdy=0",
                     max_exp, empty, beat_cnt, ovf, in_ready,
                     sbq[0].mx, sbq[0].emp, sbq[0].cnt, sbq[0].ovf);
          end
          if (out_ready) begin
            void'(sbq.pop_front());
            after_hs = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] r;
    int nb;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (!in_ready || out_valid || int'(max_exp) != MIN_V || !empty || beat_cnt != 0 || ovf) begin
      fails++;
      $display("FAIL reset_state: rdy=%0b vld=%0b max=%0d empty=%0b cnt=%0d ovf=%0b required 1 0 -256 1 0 0",
               in_ready, out_valid, max_exp, empty, beat_cnt, ovf);
    end

    // Single beat
    send_beat(pack(5, -3, 12, 7), 4'b1111, 1'b1);
    wait_drain();

    // Three beats with gaps and a held-off consumer
    stall = 1'b1;
    send_beat(pack(1, 2, 3, 4), 4'b1111, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(pack(-10, 40, 0, 0), 4'b1111, 1'b0);
    repeat (3) @(negedge clk);
    send_beat(pack(39, -128, 5, 5), 4'b1111, 1'b1);
    repeat (5) @(negedge clk);
    stall = 1'b0;
    wait_drain();

    // Masking, then a fully masked vector
    send_beat(pack(100, -5, -6, -7), 4'b1110, 1'b1);
    send_beat(pack(50, 60, 70, 80), 4'b0000, 1'b0);
    send_beat(pack(90, 91, 92, 93), 4'b0000, 1'b1);
    wait_drain();

    // Ties at MIN, then independent back-to-back vectors
    send_beat(pack(-256, -256, -256, -256), 4'b1111, 1'b1);
    send_beat(pack(100, 9, 9, 9), 4'b1111, 1'b1);
    send_beat(pack(-20, -30, -40, -20), 4'b1111, 1'b1);
    wait_drain();

    // Overflow: 17 non-final beats, final on the 18th, then a clean vector
    for (int i = 0; i < 18; i++) send_beat(pack(i, -i, 2, 3), 4'b1111, i == 17);
    send_beat(pack(1, 1, 1, 1), 4'b1111, 1'b1);
    // Exactly MAX_BEATS+1 beats: terminates without overflow
    for (int i = 0; i < 17; i++) send_beat(pack(-i, 0, -1, 4), 4'b0101, i == 16);
    wait_drain();

    // Reset in the middle of a vector
    send_beat(pack(120, 121, 122, 123), 4'b1111, 1'b0);
    send_beat(pack(124, 125, 126, 127), 4'b1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (4) @(negedge clk);
    send_beat(pack(3, 3, 3, 3), 4'b1111, 1'b1);
    wait_drain();

    // Randomized vectors
    for (int v = 0; v < 40; v++) begin
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 20) : $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        r[31:0] = $urandom();
        r[35:32] = 4'($urandom());
        send_beat(r, 4'($urandom()), b == nb - 1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pdpu_exp_max_seq.md
Name: pdpu_exp_max_seq

Overview:
- Sequencer that computes the maximum signed exponent of an arbitrarily long exponent vector, streamed N lanes per beat.
- Holds one combinational pdpu_comp_tree instance (N lanes) and reuses it across beats. A registered running maximum absorbs each beat's tree result.
- Sits ahead of the PDPU alignment stage. It supplies the vector-wide max exponent used for mantissa shifting when a dot product spans more than N elements.

Parameters:
- N, 4, lanes per beat; width of the shared comparator tree.
- WIDTH, 8, exponent magnitude bits; exponents are signed WIDTH+1 bits.
- MAX_BEATS, 16, maximum beats per vector before overflow is flagged.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- in_valid_i  input  1  beat valid
- in_ready_o  output  1  block accepts a beat
- exp_i  input  N x (WIDTH+1), signed packed  lane exponents
- mask_i  input  N  per-lane enable; 0 excludes that lane
- last_i  input  1  final beat of the current vector
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts the result
- max_exp_o  output  WIDTH+1 signed  vector maximum
- empty_o  output  1  no enabled lane in the whole vector
- beat_cnt_o  output  clog2(MAX_BEATS+1)  beats in the reported vector
- ovf_o  output  1  vector exceeded MAX_BEATS beats

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni, sampled on the rising edge.
- Reset values: state=S_IDLE, in_ready_o=1, out_valid_o=0, max_exp_o=MIN, empty_o=1, beat_cnt_o=0, ovf_o=0. MIN = -2^WIDTH (-256 for WIDTH=8).
- Reset mid-vector or mid-output drops all partial state. No result is emitted.
- Beat accept: in_valid_i & in_ready_o on a rising edge.
- Masked lanes are replaced by MIN before entering the tree.
- The tree output is compared against the running max in the same cycle. The larger value is registered; on a tie the value is unchanged.
- FSM states:
  - S_IDLE: in_ready_o=1. On accept, the running max is loaded with the tree result (the previous vector's value is discarded), beat count=1, empty = ~|mask_i. Go to S_OUT if last_i, else S_ACC.
  - S_ACC: in_ready_o=1. On accept, the running max is updated, count increments, empty &= ~|mask_i. Go to S_OUT if last_i.
  - S_OUT: in_ready_o=0, out_valid_o=1. Outputs hold stable until out_ready_i. On the handshake, go to S_IDLE the next cycle.
- Latency: out_valid_o rises the cycle after the last beat is accepted.
- in_ready_o depends on state only (registered), never combinationally on out_ready_i. There is a mandatory one-cycle input bubble after each result handshake.
- in_valid_i low in S_IDLE or S_ACC: no state change. Gaps between beats are legal.
- Overflow: if a beat is accepted while count==MAX_BEATS and last_i=0, ovf_o sets and stays set until the result handshake. The count saturates at MAX_BEATS and the max continues to update.
- A beat accepted at count==MAX_BEATS with last_i=1 terminates the vector normally. ovf_o is set only if an earlier beat already overflowed.
- empty_o=1 in a result means max_exp_o=MIN and that value must be ignored.
- Comparison is two's-complement signed over WIDTH+1 bits. No widening and no saturation are applied.
- N=1 is legal; the tree degenerates to a pass-through.

Test Plan:
- Single beat, last_i=1, exp={5,-3,12,7}, mask=4'b1111 -> next cycle out_valid_o=1, max_exp_o=12, beat_cnt_o=1, empty_o=0, ovf_o=0.
- Three beats {1,2,3,4}, {-10,40,0,0}, {39,-128,5,5} with gaps between beats; out_ready_i held low 4 cycles -> max_exp_o=40, beat_cnt_o=3, outputs stable throughout, in_ready_o=0 until the cycle after the handshake.
- Masking: {100,-5,-6,-7} with mask=4'b1110 -> max=-5. Next vector with mask=0 on all beats -> empty_o=1, max_exp_o=-256.
- Ties and negatives: all lanes -256 unmasked -> max=-256, empty_o=0. Back-to-back vectors give independent results; the second does not inherit the first max.
- Overflow: 17 beats with MAX_BEATS=16, last on the 18th -> ovf_o=1, beat_cnt_o=16. After the handshake the next vector reports ovf_o=0.
- rst_ni low for 1 cycle after 2 beats of a vector -> no out_valid_o. The next single beat {3,3,3,3} last -> max=3, beat_cnt_o=1.
